frontend_backend_fifo: RTL and testbench
========================================

Name: frontend_backend_fifo

Overview:
Decoupling queue between the Frontend ISU stage and the backend issue/EXU stage. It is the receiving end of the frontend packet interface: it consumes frontend_packet_t, drives the backend_busy stall back into the Frontend, and presents packets in program order to the backend with a valid/ready handshake. Flush discards all queued packets.

Parameters:
DEPTH, 4, number of packet entries; must be a power of two and at least 2.
PTR_W, $clog2(DEPTH), read/write pointer width (derived; do not override).
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-low (asserted at 0)
flush  input  1  pipeline flush; discard all entries
in_packet  input  frontend_packet_t  packet from Frontend ISU; in_packet.valid marks a real instruction
in_hold  input  1  ISU operands not ready (ISU busy); packet must not be taken
backend_busy  output  1  stall to Frontend; Frontend holds in_packet while 1
out_packet  output  frontend_packet_t  head entry
out_valid  output  1  head entry valid
out_ready  input  1  backend accepts head this cycle
count  output  CNT_W  current occupancy

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_packet=0, backend_busy=0. Entry storage is not reset.
- full = (count==DEPTH); empty = (count==0). backend_busy = full, derived from registered state only; no combinational path from out_ready or in_packet to backend_busy.
- push = in_packet.valid & ~in_hold & ~full & ~flush. Invalid (bubble) packets are never stored.
- pop = out_valid & out_ready & ~flush.
- On push: storage[wr_ptr] <= in_packet; wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
- On pop: rd_ptr <= rd_ptr+1, wrapping DEPTH-1 -> 0.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full is impossible, since push requires ~full. The slot freed by a pop is usable on the next cycle.
- Simultaneous push and pop when count==1: both take effect; the new entry becomes the head next cycle.
- out_packet = storage[rd_ptr], with out_valid = ~empty. out_packet is forced to 0 when empty.
- Latency: a packet pushed in cycle N is visible at out_valid in cycle N+1, unless the optional feature below is enabled.
- flush (synchronous, highest priority after reset): wr_ptr, rd_ptr and count are cleared to 0. No push or pop occurs in that cycle, and out_valid=0 from the next cycle.
- Reset mid-operation clears all state immediately; queued packets are lost.
- The block is data-transparent: operand freshness of queued packets is owned by backend issue logic. The block never modifies packet fields.

Optional Feature:
FRONTEND_FIFO_BYPASS_EN
- Defined: when empty, with in_packet.valid & ~in_hold & ~flush, out_packet = in_packet and out_valid=1 combinationally. If out_ready is also 1, the packet is consumed without being stored, and count and pointers are unchanged. If out_ready=0, it is stored normally.
- Undefined: minimum latency is one cycle, and outputs depend only on registered state.

Decomposition:
- frontend_packet_t already lives in the bundle package and is used unchanged.
- Add FRONTEND_FIFO_DEPTH (default 4) to the core configuration package. Frontend and backend top-level both instantiate with this constant.
- No sub-module: storage, pointers and counter are inline. The block is about 150 RTL lines.

Test Plan:
- Reset then push 3 valid packets (pc=0x80000000, 0x80000004, 0x80000008) with out_ready=0 -> count=3, out_valid=1, out_packet.pc=0x80000000, backend_busy=0.
- Push 4 packets with out_ready=0 (DEPTH=4) -> count=4 and backend_busy=1. A 5th packet held on in_packet is not stored. Assert out_ready for 1 cycle -> count=3, backend_busy=0 next cycle, and the 5th packet enters in the following cycle.
- Stream 10 packets with out_ready=1 continuously -> output pcs match input order exactly, pointers wrap twice, and count never exceeds 1. With FRONTEND_FIFO_BYPASS_EN defined, count stays 0.
- Present in_packet.valid=1 with in_hold=1 for 3 cycles, then in_hold=0 -> exactly one entry is stored. Also present in_packet.valid=0 -> nothing is stored.
- With count=3, assert flush together with push and pop -> next cycle count=0, out_valid=0, and no entry survives. A push 1 cycle later yields that packet as the head.
- With count=2, drive rst=0 asynchronously mid-cycle -> out_valid=0, count=0 and backend_busy=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/frontend_backend_fifo_pkg.sv
// Shared types and configuration for the frontend/backend decoupling queue.
package frontend_backend_fifo_pkg;

   // Queue depth used by both the frontend and backend top levels.
   localparam int FRONTEND_FIFO_DEPTH = 4;

   // Packet handed from the Frontend ISU stage to backend issue.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } frontend_packet_t;

endpackage

// File: rtl/frontend_backend_fifo.sv
// Frontend -> backend decoupling queue: in-order packet FIFO with full-based
// stall, valid/ready head, and flush. Optional macro FRONTEND_FIFO_BYPASS_EN
// lets a packet reach the head combinationally when the queue is empty.
module frontend_backend_fifo
   import frontend_backend_fifo_pkg::*;
#(
   parameter  int DEPTH = FRONTEND_FIFO_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  frontend_packet_t in_packet,
   input  logic             in_hold,
   output logic             backend_busy,
   output frontend_packet_t out_packet,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   frontend_packet_t r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_take;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_take  = in_packet.valid & ~in_hold & ~flush;

`ifdef FRONTEND_FIFO_BYPASS_EN
   // Empty queue and backend ready: the packet goes straight through unstored.
   assign w_bypass = w_empty & w_take & out_ready;
`else
   assign w_bypass = 1'b0;
`endif

   // Bubbles are never stored; a bypassed packet does not occupy a slot.
   assign w_push = w_take & ~w_full & ~w_bypass;
   // Only stored entries are popped; a bypassed packet leaves state untouched.
   assign w_pop  = ~w_empty & out_ready & ~flush;

   // Stall only from registered occupancy, never from out_ready or in_packet.
   assign backend_busy = w_full;
   assign count        = r_count;

   // Head presentation: stored head, else (bypass build) the incoming packet, else zero.
   always_comb begin
      out_valid  = 1'b0;
      out_packet = '0;
      if (!w_empty) begin
         out_valid  = 1'b1;
         out_packet = r_mem[r_rd_ptr];
      end
`ifdef FRONTEND_FIFO_BYPASS_EN
      else if (w_take) begin
         out_valid  = 1'b1;
         out_packet = in_packet;
      end
`endif
   end

   // Entry storage: written on push, intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_packet;
      end
   end

   // Pointers and occupancy; flush empties the queue with no push/pop that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // DEPTH is a power of two, so natural pointer overflow wraps correctly.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_frontend_backend_fifo.sv
// Self-checking bench for frontend_backend_fifo: directed scenarios followed by
// randomized traffic, compared every cycle against a queue-based reference.
// Honours FRONTEND_FIFO_BYPASS_EN in its reference model.
module tb_frontend_backend_fifo;
   import frontend_backend_fifo_pkg::*;

   localparam int DEPTH = FRONTEND_FIFO_DEPTH;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   frontend_packet_t in_packet;
   logic             in_hold;
   logic             backend_busy;
   frontend_packet_t out_packet;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] count;

   int n_vec = 0;
   int n_err = 0;

   frontend_packet_t mq[$];
   logic [31:0]      pc_ctr;
   frontend_packet_t pk;

   frontend_backend_fifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_packet    (in_packet),
      .in_hold      (in_hold),
      .backend_busy (backend_busy),
      .out_packet   (out_packet),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .count        (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic frontend_packet_t mk(input logic v, input logic [31:0] pc);
      frontend_packet_t p;
      p.valid = v;
      p.pc    = pc;
      p.instr = $urandom;
      return p;
   endfunction

   // One clock cycle: drive inputs, check outputs against the queue model,
   // advance the model, then step past the clock edge.
   task automatic cycle(input frontend_packet_t p, input logic hold, input logic rdy, input logic fl);
      bit               empty, full, take, byp, consumed;
      logic             ev;
      frontend_packet_t ep;
      in_packet = p;
      in_hold   = hold;
      out_ready = rdy;
      flush     = fl;
      #2;
      empty = (mq.size() == 0);
      full  = (mq.size() == DEPTH);
      take  = p.valid && !hold && !fl;
      byp   = 1'b0;
`ifdef FRONTEND_FIFO_BYPASS_EN
      byp   = empty && take;
`endif
      ev = !empty || byp;
      if (!empty) ep = mq[0];
      else if (byp) ep = p;
      else ep = '0;
      chk("out_valid", 128'(out_valid), 128'(ev));
      chk("out_packet", 128'(out_packet), 128'(ep));
      chk("count", 128'(count), 128'(mq.size()));
      chk("backend_busy", 128'(backend_busy), 128'(full));
      if (fl) begin
         mq.delete();
      end else begin
         consumed = 1'b0;
         if (ev && rdy) begin
            if (!empty) void'(mq.pop_front());
            else consumed = 1'b1;
         end
         if (take && !full && !consumed) mq.push_back(p);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_new(input logic hold, input logic rdy);
      cycle(mk(1'b1, pc_ctr), hold, rdy, 1'b0);
      pc_ctr = pc_ctr + 32'd4;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle('0, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      in_hold   = 1'b0;
      out_ready = 1'b0;
      in_packet = '0;
      pc_ctr    = 32'h8000_0000;

      // Reset state
      #12;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_busy", 128'(backend_busy), 128'(0));
      chk("rst_out_packet", 128'(out_packet), 128'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Three pushes with backend stalled
      for (int i = 0; i < 3; i++) push_new(1'b0, 1'b0);
      chk("fill3_count", 128'(count), 128'(3));
      chk("fill3_valid", 128'(out_valid), 128'(1));
      chk("fill3_head_pc", 128'(out_packet.pc), 128'(32'h8000_0000));
      chk("fill3_busy", 128'(backend_busy), 128'(0));
      idle(4, 1'b1);

      // Fill to DEPTH, hold a 5th packet, free one slot
      for (int i = 0; i < 4; i++) push_new(1'b0, 1'b0);
      chk("full_count", 128'(count), 128'(4));
      chk("full_busy", 128'(backend_busy), 128'(1));
      pk = mk(1'b1, pc_ctr);
      pc_ctr = pc_ctr + 32'd4;
      cycle(pk, 1'b0, 1'b0, 1'b0);
      chk("held5_count", 128'(count), 128'(4));
      cycle(pk, 1'b0, 1'b1, 1'b0);
      chk("pop1_count", 128'(count), 128'(3));
      chk("pop1_busy", 128'(backend_busy), 128'(0));
      cycle(pk, 1'b0, 1'b0, 1'b0);
      chk("enter5_count", 128'(count), 128'(4));
      idle(5, 1'b1);

      // Continuous stream with backend always ready
      for (int i = 0; i < 10; i++) begin
         push_new(1'b0, 1'b1);
         chk("stream_count_le1", 128'(count <= CNT_W'(1)), 128'(1));
      end
      idle(2, 1'b1);

      // Held packet taken once hold drops; bubbles never stored
      pk = mk(1'b1, pc_ctr);
      pc_ctr = pc_ctr + 32'd4;
      for (int i = 0; i < 3; i++) cycle(pk, 1'b1, 1'b0, 1'b0);
      chk("hold_count", 128'(count), 128'(0));
      cycle(pk, 1'b0, 1'b0, 1'b0);
      cycle(mk(1'b0, 32'h1234_5678), 1'b0, 1'b0, 1'b0);
      cycle(mk(1'b0, 32'h1234_567c), 1'b0, 1'b0, 1'b0);
      chk("hold_bubble_count", 128'(count), 128'(1));
      idle(2, 1'b1);

      // Flush with simultaneous push and pop at count=3
      for (int i = 0; i < 3; i++) push_new(1'b0, 1'b0);
      cycle(mk(1'b1, 32'hdead_beef), 1'b0, 1'b1, 1'b1);
      chk("flush_count", 128'(count), 128'(0));
      chk("flush_valid", 128'(out_valid), 128'(0));
      pk = mk(1'b1, 32'h9000_0000);
      cycle(pk, 1'b0, 1'b0, 1'b0);
      chk("postflush_head_pc", 128'(out_packet.pc), 128'(32'h9000_0000));
      chk("postflush_count", 128'(count), 128'(1));

      // Asynchronous reset mid-cycle with count=2
      push_new(1'b0, 1'b0);
      chk("prereset_count", 128'(count), 128'(2));
      in_packet = '0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", 128'(out_valid), 128'(0));
      chk("async_rst_count", 128'(count), 128'(0));
      chk("async_rst_busy", 128'(backend_busy), 128'(0));
      mq.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic v, h, r, f;
         v = ($urandom_range(0, 3) != 0);
         h = ($urandom_range(0, 4) == 0);
         r = 1'($urandom_range(0, 1));
         f = ($urandom_range(0, 30) == 0);
         cycle(mk(v, pc_ctr), h, r, f);
         pc_ctr = pc_ctr + 32'd4;
      end
      idle(6, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
